// File: rtl/riscv_ms_pkg.sv
// Shared types and limits for the multicycle RISC-V memory sequencing logic.
package riscv_ms_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } arb_state_t;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } arb_owner_t;

  localparam int MEM_LAT_MAX = 8;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that flags the last cycle of a memory read latency window.
module mem_lat_timer
  import riscv_ms_pkg::*;
#(
  parameter int W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         active,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (active && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = active && (cnt_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory between the core and a debug/loader port, one transaction at a time.
// Define RISCV_MS_DBG_PORT_EN to enable the debug requester; otherwise it is a core-only latency sequencer.
module mem_port_arbiter
  import riscv_ms_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_t state_reg, state_next;
  arb_owner_t owner_reg, owner_next;
  logic       core_win, dbg_win;
  logic       lat_load, lat_done;

  mem_lat_timer #(.W(LAT_CNT_W)) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .active   (state_reg == RD),
    .done     (lat_done)
  );

`ifdef RISCV_MS_DBG_PORT_EN
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  logic [3:0] dbg_wait_reg;

  // Starvation counter: debug takes priority once it has been refused WAIT_MAX times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_wait_reg <= '0;
    end else if (dbg_req && !dbg_win) begin
      if (dbg_wait_reg < WAIT_MAX) dbg_wait_reg <= dbg_wait_reg + 4'd1;
    end else begin
      dbg_wait_reg <= '0;
    end
  end

  assign dbg_win  = rst && (state_reg == IDLE) && dbg_req &&
                    (!core_req || (dbg_wait_reg == WAIT_MAX));
  assign core_win = rst && (state_reg == IDLE) && core_req && !dbg_win;

  assign dbg_gnt    = dbg_win;
  assign dbg_rvalid = lat_done && (owner_reg == DBG);
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata};

  assign dbg_win  = 1'b0;
  assign core_win = rst && (state_reg == IDLE) && core_req;

  assign dbg_gnt    = 1'b0;
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= CORE;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    lat_load   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        if (core_win) begin
          mem_en    = 1'b1;
          mem_we    = core_we;
          mem_addr  = core_addr;
          mem_wdata = core_wdata;
          if (!core_we) begin
            state_next = RD;
            owner_next = CORE;
            lat_load   = 1'b1;
          end
        end else if (dbg_win) begin
          mem_en    = 1'b1;
          mem_we    = dbg_we;
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
          if (!dbg_we) begin
            state_next = RD;
            owner_next = DBG;
            lat_load   = 1'b1;
          end
        end
      end
      RD: begin
        if (lat_done) state_next = IDLE;
      end
    endcase
  end

  assign core_gnt    = core_win;
  assign core_rvalid = lat_done && (owner_reg == CORE);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  // The rvalid cycle itself releases the core, so only earlier read cycles stall it.
  assign core_stall  = (core_req && !core_win) ||
                       ((state_reg == RD) && (owner_reg == CORE) && !lat_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, randomized model check.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int MW  = 4;
`ifdef RISCV_MS_DBG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic creq = 0, cwe = 0, dreq = 0, dwe = 0;
  logic [AW-1:0] caddr = '0, daddr = '0;
  logic [DW-1:0] cwdata = '0, dwdata = '0, mrdata = '0;
  logic core_gnt, core_rvalid, core_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [DW-1:0] core_rdata, dbg_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .core_req(creq), .core_we(cwe), .core_addr(caddr), .core_wdata(cwdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dreq), .dbg_we(dwe), .dbg_addr(daddr), .dbg_wdata(dwdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mrdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        rst, creq, cwe;
    logic [31:0] caddr, cwdata, mrd;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        stall, men, mwe;
    logic [31:0] maddr;
  } vec_t;

  function automatic vec_t mk(input logic r, cq, cw, input logic [31:0] ca, cd, md,
                              input logic g, v, input logic [31:0] rd,
                              input logic s, me, mw, input logic [31:0] ma);
    vec_t x;
    x = '{r, cq, cw, ca, cd, md, g, v, rd, s, me, mw, ma};
    return x;
  endfunction

  vec_t vt[20];

  // reference model state (cycle-indexed read completion)
  longint cyc, due;
  int     waitc;
  bit     rd_dbg;
  bit     e_cg, e_dg, e_rv, e_stall, idle, c_prev, d_prev;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_we;
  int got, ncore, idx;

  initial begin
    // MEM_LAT=3 core-only scenarios, one row per cycle
    vt[0]  = mk(0, 0, 0, 0,     0,    0,           0, 0, 0,           0, 0, 0, 0);
    vt[1]  = mk(1, 1, 0, 'h10,  0,    0,           1, 0, 0,           0, 1, 0, 'h10);
    vt[2]  = mk(1, 0, 0, 0,     0,    0,           0, 0, 0,           1, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 0,     0,    0,           0, 0, 0,           1, 0, 0, 0);
    vt[4]  = mk(1, 0, 0, 0,     0,    'hDEADBEEF,  0, 1, 'hDEADBEEF,  0, 0, 0, 0);
    vt[5]  = mk(1, 1, 1, 'h20,  'h77, 0,           1, 0, 0,           0, 1, 1, 'h20);
    vt[6]  = mk(1, 1, 1, 'h24,  'h78, 0,           1, 0, 0,           0, 1, 1, 'h24);
    vt[7]  = mk(1, 1, 0, 'h30,  0,    0,           1, 0, 0,           0, 1, 0, 'h30);
    vt[8]  = mk(1, 1, 1, 'h34,  'h99, 0,           0, 0, 0,           1, 0, 0, 0);
    vt[9]  = mk(1, 1, 1, 'h34,  'h99, 0,           0, 0, 0,           1, 0, 0, 0);
    vt[10] = mk(1, 1, 1, 'h34,  'h99, 'h12345678,  0, 1, 'h12345678,  1, 0, 0, 0);
    vt[11] = mk(1, 1, 1, 'h34,  'h99, 0,           1, 0, 0,           0, 1, 1, 'h34);
    vt[12] = mk(1, 1, 0, 'h50,  0,    0,           1, 0, 0,           0, 1, 0, 'h50);
    vt[13] = mk(0, 0, 0, 0,     0,    'hAAAA,      0, 0, 0,           0, 0, 0, 0);
    vt[14] = mk(1, 0, 0, 0,     0,    'hAAAA,      0, 0, 0,           0, 0, 0, 0);
    vt[15] = mk(1, 0, 0, 0,     0,    'hAAAA,      0, 0, 0,           0, 0, 0, 0);
    vt[16] = mk(1, 1, 0, 'h60,  0,    0,           1, 0, 0,           0, 1, 0, 'h60);
    vt[17] = mk(1, 0, 0, 0,     0,    0,           0, 0, 0,           1, 0, 0, 0);
    vt[18] = mk(1, 0, 0, 0,     0,    0,           0, 0, 0,           1, 0, 0, 0);
    vt[19] = mk(1, 0, 0, 0,     0,    'hCAFEF00D,  0, 1, 'hCAFEF00D,  0, 0, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst; creq = vt[i].creq; cwe = vt[i].cwe;
      caddr = vt[i].caddr; cwdata = vt[i].cwdata; mrdata = vt[i].mrd;
      #1;
      chk($sformatf("vec%0d_core_gnt", i), core_gnt, vt[i].gnt);
      chk($sformatf("vec%0d_core_rvalid", i), core_rvalid, vt[i].rv);
      chk($sformatf("vec%0d_core_rdata", i), core_rdata, vt[i].rdata);
      chk($sformatf("vec%0d_core_stall", i), core_stall, vt[i].stall);
      chk($sformatf("vec%0d_mem_en", i), mem_en, vt[i].men);
      chk($sformatf("vec%0d_mem_we", i), mem_we, vt[i].mwe);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].maddr);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vt[i].men ? vt[i].cwdata : 32'h0);
      chk($sformatf("vec%0d_dbg_gnt", i), dbg_gnt, 1'b0);
      tick();
    end
    creq = 0; cwe = 0; caddr = 0; cwdata = 0; mrdata = 0;
    tick();

`ifdef RISCV_MS_DBG_PORT_EN
    // debug write while idle: same-cycle grant, FSM stays idle
    dreq = 1; dwe = 1; daddr = 'h40; dwdata = 'h55;
    #1;
    chk("dbgwr_gnt", dbg_gnt, 1); chk("dbgwr_mem_en", mem_en, 1); chk("dbgwr_mem_we", mem_we, 1);
    chk("dbgwr_mem_addr", mem_addr, 'h40); chk("dbgwr_mem_wdata", mem_wdata, 'h55);
    tick();
    dreq = 0; creq = 1; cwe = 1; caddr = 'h44; cwdata = 1;
    #1;
    chk("dbgwr_then_core_gnt", core_gnt, 1);
    tick();
    creq = 0;

    // contention: core writes back-to-back, debug waits out the starvation limit
    creq = 1; cwe = 1; dreq = 1; dwe = 1; daddr = 'h80; dwdata = 'h81;
    got = 0; ncore = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      caddr = 32'(i * 4);
      #1;
      if (dbg_gnt) begin
        got = 1;
        chk("contention_core_stall", core_stall, 1);
        chk("contention_core_gnt", core_gnt, 0);
      end else if (core_gnt) begin
        ncore++;
      end
      tick();
    end
    chk("contention_dbg_served", got, 1);
    chk("contention_core_wins", ncore, MW);
    creq = 0; dreq = 0;

    // core request while a debug read is in flight
    dreq = 1; dwe = 0; daddr = 'h90; mrdata = 'h5A5A5A5A;
    #1;
    chk("dbgrd_gnt", dbg_gnt, 1);
    tick();
    dreq = 0; creq = 1; cwe = 0; caddr = 'hA0;
    got = 0; idx = -1;
    for (int i = 0; i < 8 && got == 0; i++) begin
      #1;
      chk("dbgrd_busy_core_gnt", core_gnt, 0);
      if (dbg_rvalid) begin
        got = 1; idx = i;
        chk("dbgrd_rdata", dbg_rdata, 'h5A5A5A5A);
      end
      tick();
    end
    chk("dbgrd_rvalid_seen", got, 1);
    chk("dbgrd_latency", idx, LAT - 1);
    #1;
    chk("core_gnt_after_dbg_rvalid", core_gnt, 1);
    tick();
    creq = 0;
    repeat (LAT) tick();
`else
    // debug port disabled: debug ignored, core read timing unchanged
    dreq = 1; dwe = 1; daddr = 'h40; creq = 1; cwe = 0; caddr = 'h10; mrdata = 'h1234;
    #1;
    chk("nodbg_dbg_gnt", dbg_gnt, 0);
    chk("nodbg_core_gnt", core_gnt, 1);
    tick();
    creq = 0;
    for (int i = 1; i <= LAT; i++) begin
      #1;
      chk("nodbg_dbg_gnt_rd", dbg_gnt, 0);
      chk("nodbg_core_rvalid", core_rvalid, i == LAT);
      tick();
    end
    #1;
    chk("nodbg_alone_gnt", dbg_gnt, 0);
    chk("nodbg_alone_mem_en", mem_en, 0);
    tick();
    dreq = 0;
`endif

    // randomized traffic against the cycle-level reference model
    rst = 0; creq = 0; dreq = 0;
    tick();
    rst = 1;
    cyc = 0; due = -1; waitc = 0; rd_dbg = 0; c_prev = 0; d_prev = 0;
    for (int n = 0; n < 800; n++) begin
      if (!creq || c_prev) begin
        creq = 1'($urandom_range(0, 1)); cwe = 1'($urandom_range(0, 1));
        caddr = $urandom; cwdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        creq = 0;
      end
      if (!dreq || d_prev) begin
        dreq = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
        daddr = $urandom; dwdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        dreq = 0;
      end
      rst = ($urandom_range(0, 59) != 0);
      mrdata = $urandom;
      if (!rst) begin
        due = -1; waitc = 0;
      end
      idle    = rst && (cyc > due);
      e_dg    = DBG_EN && idle && dreq && (!creq || waitc >= MW);
      e_cg    = idle && creq && !e_dg;
      e_rv    = rst && (cyc == due);
      e_stall = (creq && !e_cg) || ((cyc < due) && !rd_dbg);
      e_we    = e_cg ? cwe : (e_dg ? dwe : 1'b0);
      e_addr  = e_cg ? caddr : (e_dg ? daddr : '0);
      e_wdata = e_cg ? cwdata : (e_dg ? dwdata : '0);
      #1;
      chk("rnd_core_gnt", core_gnt, e_cg);
      chk("rnd_dbg_gnt", dbg_gnt, e_dg);
      chk("rnd_core_rvalid", core_rvalid, e_rv && !rd_dbg);
      chk("rnd_dbg_rvalid", dbg_rvalid, e_rv && rd_dbg);
      chk("rnd_core_rdata", core_rdata, (e_rv && !rd_dbg) ? mrdata : '0);
      chk("rnd_dbg_rdata", dbg_rdata, (e_rv && rd_dbg) ? mrdata : '0);
      chk("rnd_core_stall", core_stall, e_stall);
      chk("rnd_mem_en", mem_en, e_cg || e_dg);
      chk("rnd_mem_we", mem_we, e_we);
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_mem_wdata", mem_wdata, e_wdata);
      c_prev = e_cg; d_prev = e_dg;
      tick();
      if (rst) begin
        if (e_cg && !cwe) begin due = cyc + LAT; rd_dbg = 0; end
        if (e_dg && !dwe) begin due = cyc + LAT; rd_dbg = 1; end
        waitc = (DBG_EN && dreq && !e_dg) ? ((waitc < MW) ? waitc + 1 : MW) : 0;
      end
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
